// File: rtl/sd_cmd_arbiter.sv
// Two-requester SD command arbiter: grants the host register path or the data
// controller, issues the frame to the serial host and collects its response or a timeout.
module sd_cmd_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_host,
    input  logic [39:0] cmd_host,
    input  logic        rsp_exp_host,
    input  logic        req_data,
    input  logic [39:0] cmd_data,
    input  logic        rsp_exp_data,
    output logic        gnt_host,
    output logic        gnt_data,
    output logic        done_host,
    output logic        done_data,
    output logic [39:0] rsp_out,
    output logic        timeout_out,
    output logic        req_out,
    output logic [39:0] cmd_out,
    input  logic        ack_in,
    input  logic        req_in,
    input  logic [39:0] cmd_in,
    output logic        ack_out,
    output logic        idle_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic        gnt_host_q;
    logic        gnt_data_q;
    logic        last_data_q;
    logic        rsp_exp_q;
    logic [39:0] cmd_q;
    logic [39:0] rsp_q;
    logic [15:0] cnt_q;
    logic        done_host_q;
    logic        done_data_q;
    logic        timeout_q;
    logic        ack_q;
    logic        pick_data_d;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        pick_data_d = req_data && (!req_host || !last_data_q);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_host_q  <= 1'b0;
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            rsp_exp_q   <= 1'b0;
            cmd_q       <= '0;
            rsp_q       <= '0;
            cnt_q       <= '0;
            done_host_q <= 1'b0;
            done_data_q <= 1'b0;
            timeout_q   <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            done_host_q <= 1'b0;
            done_data_q <= 1'b0;
            timeout_q   <= 1'b0;
            ack_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_host || req_data) begin
                        gnt_data_q <= pick_data_d;
                        gnt_host_q <= !pick_data_d;
                        cmd_q      <= pick_data_d ? cmd_data : cmd_host;
                        rsp_exp_q  <= pick_data_d ? rsp_exp_data : rsp_exp_host;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ack_in) begin
                        cnt_q <= '0;
                        if (rsp_exp_q) begin
                            state_q <= WAIT_RSP;
                        end else begin
                            done_host_q <= gnt_host_q;
                            done_data_q <= gnt_data_q;
                            state_q     <= DONE;
                        end
                    end
                end
                WAIT_RSP: begin
                    // A response arriving on the expiry cycle still counts as a response.
                    if (req_in) begin
                        rsp_q       <= cmd_in;
                        ack_q       <= 1'b1;
                        done_host_q <= gnt_host_q;
                        done_data_q <= gnt_data_q;
                        state_q     <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q   <= 1'b1;
                        done_host_q <= gnt_host_q;
                        done_data_q <= gnt_data_q;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    last_data_q <= gnt_data_q;
                    gnt_host_q  <= 1'b0;
                    gnt_data_q  <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_host    = gnt_host_q;
    assign gnt_data    = gnt_data_q;
    assign done_host   = done_host_q;
    assign done_data   = done_data_q;
    assign rsp_out     = rsp_q;
    assign timeout_out = timeout_q;
    assign ack_out     = ack_q;
    assign cmd_out     = cmd_q;
    assign req_out     = (state_q == ISSUE);
    assign idle_out    = (state_q == IDLE);

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Scoreboard bench for sd_cmd_arbiter: a transaction-level model predicts each
// completion when the command is issued; a monitor checks it when the done pulse shows.
module tb_sd_cmd_arbiter;

    localparam int TO = 8;

    typedef struct {
        bit          host;
        logic [39:0] cmd;
        int          done_cyc;
        bit          to;
        logic [39:0] rsp;
        bit          ack;
    } exp_t;

    logic        clock = 0, reset = 0;
    logic        req_host = 0, rsp_exp_host = 0, req_data = 0, rsp_exp_data = 0;
    logic [39:0] cmd_host = '0, cmd_data = '0, cmd_in = '0;
    logic        ack_in = 0, req_in = 0;
    logic        gnt_host, gnt_data, done_host, done_data, timeout_out;
    logic        req_out, ack_out, idle_out;
    logic [39:0] rsp_out, cmd_out;

    sd_cmd_arbiter #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_host(req_host), .cmd_host(cmd_host), .rsp_exp_host(rsp_exp_host),
        .req_data(req_data), .cmd_data(cmd_data), .rsp_exp_data(rsp_exp_data),
        .gnt_host(gnt_host), .gnt_data(gnt_data),
        .done_host(done_host), .done_data(done_data),
        .rsp_out(rsp_out), .timeout_out(timeout_out),
        .req_out(req_out), .cmd_out(cmd_out), .ack_in(ack_in),
        .req_in(req_in), .cmd_in(cmd_in), .ack_out(ack_out), .idle_out(idle_out)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    int cyc = 0;

    // Inputs as the DUT sampled them at the most recent rising edge.
    bit          s_rst = 0;
    logic        s_req_host = 0, s_req_data = 0, s_rsp_exp_host = 0, s_rsp_exp_data = 0;
    logic [39:0] s_cmd_host = '0, s_cmd_data = '0;
    always @(posedge clock) begin
        cyc            <= cyc + 1;
        s_rst          <= reset;
        s_req_host     <= req_host;
        s_req_data     <= req_data;
        s_rsp_exp_host <= rsp_exp_host;
        s_rsp_exp_data <= rsp_exp_data;
        s_cmd_host     <= cmd_host;
        s_cmd_data     <= cmd_data;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    exp_t sb[$];

    // Stimulus knobs: knob_ack<0 random ack delay; knob_d=-2 random, -1 no response.
    int          knob_ack = 0, knob_d = -1;
    bit          use_frame = 0;
    logic [39:0] knob_frame = '0;
    bit          own_h = 0, own_d = 0, raise_en = 0, pend_h = 0, pend_d = 0;

    // Reference model and serial-host / requester driver.
    bit          in_txn = 0, m_last_data = 0, pd, rx;
    int          ack_at = -1, rin_at = -1, a_dly, d_dly, last_gnt_cyc = 0, last_ack_cyc = 0;
    logic [39:0] m_last_rsp = '0, rin_frame = '0, frame;
    exp_t        e_new;

    always @(negedge clock) begin
        if (!s_rst) begin
            in_txn = 0; ack_at = -1; rin_at = -1;
            ack_in = 0; req_in = 0; cmd_in = '0;
            m_last_data = 0; m_last_rsp = '0;
            sb.delete();
        end else begin
            ack_in = 0; req_in = 0;
            cmd_in = {8'($urandom), 32'($urandom)};
            if (req_out && !in_txn) begin
                chk("arb_request_present", 64'(s_req_host | s_req_data), 64'd1);
                pd = s_req_data && (!s_req_host || !m_last_data);
                m_last_data = pd;
                e_new.host = !pd;
                e_new.cmd  = pd ? s_cmd_data : s_cmd_host;
                rx         = pd ? s_rsp_exp_data : s_rsp_exp_host;
                a_dly = (knob_ack < 0) ? int'($urandom_range(0, 3)) : knob_ack;
                ack_at = cyc + a_dly; last_gnt_cyc = cyc; last_ack_cyc = ack_at; in_txn = 1;
                frame = use_frame ? knob_frame : {8'($urandom), 32'($urandom)};
                if (!rx) begin
                    e_new.done_cyc = ack_at + 1; e_new.to = 0; e_new.ack = 0; e_new.rsp = m_last_rsp;
                    rin_at = ($urandom % 4 == 0) ? ack_at + 1 : -1;
                end else begin
                    d_dly = (knob_d == -2) ? (($urandom % 5 == 0) ? -1 : int'($urandom_range(0, TO + 1))) : knob_d;
                    if (d_dly >= 0 && d_dly < TO) begin
                        e_new.done_cyc = ack_at + 2 + d_dly; e_new.to = 0; e_new.ack = 1;
                        e_new.rsp = frame; m_last_rsp = frame;
                    end else begin
                        e_new.done_cyc = ack_at + 1 + TO; e_new.to = 1; e_new.ack = 0;
                        e_new.rsp = m_last_rsp;
                    end
                    rin_at = (d_dly >= 0) ? ack_at + 1 + d_dly : -1;
                end
                rin_frame = frame;
                sb.push_back(e_new);
            end
            if (in_txn && cyc == ack_at) begin
                ack_in = 1; in_txn = 0;
            end else if (!req_out && $urandom % 8 == 0) begin
                ack_in = 1;
            end
            if (cyc == rin_at) begin
                req_in = 1; cmd_in = rin_frame;
            end
            if (own_h) begin
                if (done_host) begin
                    req_host = 0; pend_h = 0;
                end else if (pend_h && gnt_host && req_host && $urandom % 16 == 0) begin
                    req_host = 0;
                end else if (!pend_h && raise_en && $urandom % 2 == 0) begin
                    req_host = 1; pend_h = 1; rsp_exp_host = 1'($urandom);
                    cmd_host = {8'($urandom), 32'($urandom)};
                end
            end
            if (own_d) begin
                if (done_data) begin
                    req_data = 0; pend_d = 0;
                end else if (pend_d && gnt_data && req_data && $urandom % 16 == 0) begin
                    req_data = 0;
                end else if (!pend_d && raise_en && $urandom % 2 == 0) begin
                    req_data = 1; pend_d = 1; rsp_exp_data = 1'($urandom);
                    cmd_data = {8'($urandom), 32'($urandom)};
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse.
    int          ndone = 0, last_done_cyc = 0;
    bit          p_idle = 0, last_to = 0, last_ack = 0, last_host = 0;
    bit          win_log[$];
    logic [39:0] last_rsp = '0;
    exp_t        e_got;

    always @(negedge clock) begin
        if (!s_rst) begin
            p_idle = 0;
        end else begin
            chk("gnt_onehot", 64'(gnt_host & gnt_data), 64'd0);
            if (p_idle && (s_req_host || s_req_data))
                chk("grant_latency", {62'd0, req_out, idle_out}, 64'd2);
            if (done_host || done_data) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e_got = sb.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e_got.done_cyc));
                    chk("done_who", {62'd0, done_host, done_data}, e_got.host ? 64'd2 : 64'd1);
                    chk("gnt_in_done", {62'd0, gnt_host, gnt_data}, e_got.host ? 64'd2 : 64'd1);
                    chk("cmd_out", 64'(cmd_out), 64'(e_got.cmd));
                    chk("rsp_out", 64'(rsp_out), 64'(e_got.rsp));
                    chk("timeout_out", 64'(timeout_out), 64'(e_got.to));
                    chk("ack_out", 64'(ack_out), 64'(e_got.ack));
                end
                win_log.push_back(done_host);
                last_done_cyc = cyc; last_rsp = rsp_out; last_to = timeout_out;
                last_ack = ack_out; last_host = done_host;
                ndone++;
            end else begin
                chk("stray_ack_or_timeout", {62'd0, ack_out, timeout_out}, 64'd0);
                if (sb.size() > 0 && sb[0].done_cyc < cyc) begin
                    chk("done_missing", 64'd1, 64'd0);
                    void'(sb.pop_front());
                end
            end
            p_idle = idle_out;
        end
    end

    task automatic tick();
        @(negedge clock); #1;
    endtask

    task automatic wait_ndone(input int tgt, input int budget);
        int n = 0;
        while (ndone < tgt && n < budget) begin tick(); n++; end
        chk("done_within_budget", 64'(ndone >= tgt), 64'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_idle_out", 64'(idle_out), 64'd1);
        chk("rst_gnt", {62'd0, gnt_host, gnt_data}, 64'd0);
        chk("rst_done", {62'd0, done_host, done_data}, 64'd0);
        chk("rst_rsp_out", 64'(rsp_out), 64'd0);
        chk("rst_cmd_out", 64'(cmd_out), 64'd0);
        chk("rst_misc", {61'd0, req_out, ack_out, timeout_out}, 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, n;
        repeat (3) tick();
        chk_reset_outputs();

        // Tie held from reset: data, host, data.
        req_host = 1; cmd_host = 40'h11_0000_0001; rsp_exp_host = 0;
        req_data = 1; cmd_data = 40'h4C_0000_0000; rsp_exp_data = 0;
        knob_ack = 0;
        base = win_log.size();
        reset = 1;
        wait_ndone(3, 200);
        req_host = 0; req_data = 0;
        if (win_log.size() >= base + 3) begin
            chk("rr_first_data", 64'(win_log[base]), 64'd0);
            chk("rr_then_host", 64'(win_log[base + 1]), 64'd1);
            chk("rr_then_data", 64'(win_log[base + 2]), 64'd0);
        end
        repeat (3) tick();

        // Host command with response, ack two cycles after req_out.
        knob_ack = 2; knob_d = 3; use_frame = 1; knob_frame = 40'h01_0000_0900;
        cmd_host = 40'h40_0000_0000; rsp_exp_host = 1; req_host = 1;
        wait_ndone(ndone + 1, 100);
        req_host = 0;
        chk("host_rsp_who", 64'(last_host), 64'd1);
        chk("host_rsp_frame", 64'(last_rsp), 64'h01_0000_0900);
        chk("host_rsp_timeout", 64'(last_to), 64'd0);
        chk("host_rsp_ack", 64'(last_ack), 64'd1);
        repeat (3) tick();

        // No response: done 8 cycles after entering WAIT_RSP, frame unchanged.
        knob_ack = 0; knob_d = -1;
        cmd_data = 40'h4C_1234_5678; rsp_exp_data = 1; req_data = 1;
        wait_ndone(ndone + 1, 100);
        req_data = 0;
        chk("timeout_latency", 64'(last_done_cyc - (last_ack_cyc + 1)), 64'd8);
        chk("timeout_flag", 64'(last_to), 64'd1);
        chk("timeout_rsp_kept", 64'(last_rsp), 64'h01_0000_0900);
        repeat (3) tick();

        // Response on the expiry cycle wins.
        knob_d = TO - 1; knob_frame = 40'h12_3456_789A;
        cmd_host = 40'h4D_0000_0000; rsp_exp_host = 1; req_host = 1;
        wait_ndone(ndone + 1, 100);
        req_host = 0;
        chk("expiry_rsp_timeout", 64'(last_to), 64'd0);
        chk("expiry_rsp_frame", 64'(last_rsp), 64'h12_3456_789A);
        chk("expiry_rsp_latency", 64'(last_done_cyc - (last_ack_cyc + 1)), 64'd8);
        repeat (3) tick();

        // No response expected, immediate ack: grant in IDLE, ISSUE, DONE.
        cmd_data = 40'h4C_0000_0000; rsp_exp_data = 0; req_data = 1;
        wait_ndone(ndone + 1, 100);
        req_data = 0;
        chk("fast_done_latency", 64'(last_done_cyc - last_gnt_cyc), 64'd1);
        chk("fast_done_no_ack", 64'(last_ack), 64'd0);
        repeat (3) tick();

        // Reset while waiting for a response: abort, then data wins the tie.
        knob_d = -1; cmd_data = 40'h4C_0000_0001; rsp_exp_data = 1; req_data = 1;
        n = 0;
        while (!req_out && n < 50) begin tick(); n++; end
        chk("saw_req_out", 64'(req_out), 64'd1);
        repeat (3) tick();
        base = ndone;
        reset = 0;
        req_host = 1; rsp_exp_host = 0; rsp_exp_data = 0;
        tick();
        chk_reset_outputs();
        chk("no_done_on_abort", 64'(ndone), 64'(base));
        reset = 1;
        wait_ndone(ndone + 1, 100);
        req_host = 0; req_data = 0;
        chk("post_reset_tie_data", 64'(last_host), 64'd0);
        repeat (3) tick();

        // Randomised traffic from both requesters.
        knob_ack = -1; knob_d = -2; use_frame = 0;
        own_h = 1; own_d = 1; raise_en = 1;
        wait_ndone(ndone + 250, 30000);
        raise_en = 0;
        n = 0;
        while ((pend_h || pend_d || sb.size() != 0 || !idle_out) && n < 500) begin tick(); n++; end
        chk("drained", 64'(pend_h || pend_d || sb.size() != 0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
